// File: rtl/oclib_pkg.sv
// Shared oclib types: 32-bit CSR request/completion structs and common defaults.
package oclib_pkg;

  localparam integer DefaultCsrArbTimeout = 1024;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping.
module oclib_rr_arbiter #(
  parameter int unsigned Requesters = 2
) (
  input  logic [Requesters-1:0]         request_i,
  input  logic [$clog2(Requesters)-1:0] last_grant_i,
  output logic                          grant_valid_o,
  output logic [$clog2(Requesters)-1:0] grant_o
);

  localparam int unsigned IdxW = $clog2(Requesters);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_o       = last_grant_i;
    cand          = '0;
    // Offset Requesters wraps back to last_grant_i, so it is considered last.
    for (int unsigned off = 1; off <= Requesters; off++) begin
      cand = IdxW'((32'(last_grant_i) + off) % Requesters);
      if (!grant_valid_o && request_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_o       = cand;
      end
    end
  end

endmodule

// File: rtl/oclib_csr_32_arbiter.sv
// Round-robin arbiter serialising whole CSR transactions onto one downstream target.
// Optional watchdog enabled by defining OCLIB_CSR_32_ARBITER_TIMEOUT_EN.
module oclib_csr_32_arbiter
  import oclib_pkg::*;
#(
  parameter int unsigned  Requesters    = 2,
  parameter int unsigned  TimeoutCycles = DefaultCsrArbTimeout,
  localparam int unsigned IdxW          = $clog2(Requesters)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  csr_32_s         in_i [Requesters],
  output csr_32_fb_s      in_fb_o [Requesters],
  output csr_32_s         out_o,
  input  csr_32_fb_s      out_fb_i,
  output logic [IdxW-1:0] grant_index_o,
  output logic            busy_o,
  output logic            timeout_pulse_o
);

  if (Requesters < 2 || Requesters > 16 || TimeoutCycles < 1) begin : gen_param_check
    $fatal(1, "oclib_csr_32_arbiter: illegal Requesters or TimeoutCycles");
  end

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;
  logic [IdxW-1:0]   rr_grant;
  logic              rr_valid;
  logic [Requesters-1:0] req;
  csr_32_s           out_q, out_d;
  csr_32_fb_s        resp_q, resp_d;
  logic              expired;
  logic              timeout_q;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < Requesters; i++) begin
      req[i] = in_i[i].read | in_i[i].write;
    end
  end

  oclib_rr_arbiter #(
    .Requesters (Requesters)
  ) u_rr_arbiter (
    .request_i     (req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (rr_valid),
    .grant_o       (rr_grant)
  );

`ifdef OCLIB_CSR_32_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_d;

  assign expired   = (cnt_q == CntW'(TimeoutCycles));
  assign timeout_d = (state_q == StReq) && !out_fb_i.ready && expired;

  // Cleared in IDLE so it restarts at zero on REQ entry; saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != StReq) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign expired   = 1'b0;
  assign timeout_q = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(Requesters - 1);
      out_q        <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_q        <= out_d;
      resp_q       <= resp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_d        = out_q;
    resp_d       = resp_q;
    case (state_q)
      StIdle: begin
        if (rr_valid) begin
          state_d      = StReq;
          last_grant_d = rr_grant;
          out_d        = in_i[rr_grant];
        end
      end
      StReq: begin
        // A real completion wins over a watchdog expiry on the same cycle.
        if (out_fb_i.ready) begin
          state_d      = StResp;
          out_d        = '0;
          resp_d.ready = 1'b1;
          resp_d.error = out_fb_i.error;
          resp_d.rdata = out_fb_i.rdata;
        end else if (expired) begin
          state_d = StResp;
          out_d   = '0;
          resp_d  = '{ready: 1'b1, error: 1'b1, rdata: 32'h0};
        end
      end
      StResp: begin
        state_d = StIdle;
        resp_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_o           = out_q;
    busy_o          = (state_q != StIdle);
    grant_index_o   = last_grant_q;
    timeout_pulse_o = timeout_q;
    for (int unsigned i = 0; i < Requesters; i++) begin
      in_fb_o[i] = (state_q == StResp && last_grant_q == IdxW'(i)) ? resp_q : '0;
    end
  end

endmodule

// File: doc/oclib_csr_32_arbiter.md
# oclib_csr_32_arbiter

Round-robin arbiter sharing one downstream `csr_32_s` target among `Requesters` upstream CSR masters. It sits between several control agents and a single CSR block or tree port. Examples of control agents are the UART/byte-channel CSR bridge, a soft CPU and a PCIe BAR bridge. It serializes whole transactions: one request is forwarded, its completion is returned, and only then is the next requester granted. An optional watchdog converts a hung target into an error completion.

## Interface
- `Requesters`, 2: number of upstream masters, legal range 2..16.
- `TimeoutCycles`, 1024: watchdog limit in cycles, counted from downstream request assertion; used only when the watchdog is compiled in.
- `clock`  in  1: single clock; all logic is rising-edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `in`  in  `Requesters` x `csr_32_s`: upstream requests.
- `inFb`  out  `Requesters` x `csr_32_fb_s`: upstream completions.
- `out`  out  `csr_32_s`: downstream request.
- `outFb`  in  `csr_32_fb_s`: downstream completion.
- `grantIndex`  out  $clog2(`Requesters`): index of the current or last granted requester (debug).
- `busy`  out  1: high outside IDLE.
- `timeoutPulse`  out  1: one-cycle pulse when the watchdog fires; constant 0 when the watchdog is not compiled in.

## Operation
- Protocol rules for each requester:
  - A request is `read|write`; the requester holds the request fields stable until it sees `ready`.
  - The requester drops `read`/`write` on the cycle after `ready`.
  - The target pulses `ready`, with `rdata` and `error` valid, for one cycle.
- State machine:
  - IDLE: if any `in[i].read|write` is set, pick a winner by round-robin and latch `in[winner]` into `out`. Go to REQ.
  - REQ: `out.read/write` asserted and held. On `outFb.ready`, latch `rdata`/`error` and go to RESP.
  - RESP: drive `inFb[grant].ready=1` with the latched `rdata`/`error`; `out.read/write`=0. Go to IDLE.
- Round-robin:
  - Search starts at `lastGrant+1` modulo `Requesters`.
  - `lastGrant` resets to `Requesters-1`, so requester 0 wins first.
  - `lastGrant` updates on entry to REQ.
- `read` and `write` both set: forwarded unchanged. The arbiter does not judge legality.
- A requester that drops its request mid-transaction is ignored. The downstream transaction still completes, and the RESP pulse is still driven.
- Non-granted `inFb[i]` are all-zero at all times.
- Requests arriving while busy wait. There is no queueing beyond the held request itself.

## Timing
- Reset values: `out`=0, all `inFb`=0, `busy`=0, `grantIndex`=`Requesters-1`, `timeoutPulse`=0. State is IDLE.
- Reset applies asynchronously, including mid-transaction: the downstream request is dropped immediately and no completion is returned.
- Latencies (all outputs registered):
  - Request seen in IDLE at cycle 0: `out` asserted from cycle 1.
  - `outFb.ready` at cycle k: upstream `ready` at k+1, and `out.read/write`=0 at k+1.
  - IDLE again at k+2, so the minimum turnaround is 3 cycles per transaction.
- `outFb.ready` in IDLE or RESP is ignored.

## Configuration
- `OCLIB_CSR_32_ARBITER_TIMEOUT_EN` defined:
  - A counter starts at entry to REQ.
  - If `outFb.ready` has not arrived after `TimeoutCycles` cycles, go to RESP with `ready=1`, `error=1`, `rdata=0`, and pulse `timeoutPulse`.
  - `outFb.ready` on the same cycle as expiry takes priority over the timeout (normal completion).
  - The counter width is $clog2(`TimeoutCycles`+1); it saturates and never wraps.
- Macro undefined: no counter; REQ waits indefinitely; `timeoutPulse` is tied 0.

## Structure
- Uses `oclib_pkg::csr_32_s` and `oclib_pkg::csr_32_fb_s`.
- Add `localparam integer DefaultCsrArbTimeout = 1024` to `oclib_pkg`.
- The state enum stays local to the module.
- One sub-module: `oclib_rr_arbiter`, a combinational round-robin pick with parameter `Requesters`.
  - Inputs: `request` vector and `lastGrant`.
  - Outputs: `grantValid` and `grant` index.
  - Reusable by other oclib arbiters.

## Test plan
- Single requester: requester 1 reads 0x10, target returns `rdata`=0xDEADBEEF at k → `inFb[1].ready`=1 and `rdata`=0xDEADBEEF at k+1; `out.read`=0 at k+1; `busy`=0 at k+2.
- Fairness: all 4 requesters held continuously with `Requesters`=4 → grant order 0,1,2,3,0,1; no requester granted twice before the others are served.
- Back-pressure: target delays `ready` 50 cycles → `out` fields stable for all 50 cycles; other requesters stay pending; their `inFb` stay 0.
- Error pass-through: target returns `error`=1 → requester sees `ready`=1 and `error`=1; the next grant proceeds normally.
- Reset mid-transaction: `resetn` low during REQ → `out`=0 and `inFb`=0 asynchronously; after release, requester 0 wins first.
- Timeout (macro defined, `TimeoutCycles`=8): target never replies → at cycle 9 after REQ entry, `error`=1, `ready`=1, `rdata`=0, `timeoutPulse`=1. With the macro undefined, the bench observes no completion after 1000 cycles.
